// File: rtl/pipe_control.sv
// Pipelined control unit: decodes the ID opcode into a 9-bit control word and carries it
// through the ID/EX, EX/MEM and MEM/WB latches, with load-use stall, MEM flush and stall counter.
module pipe_control #(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned EN_ADDI = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  opcode,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             flush,
  output logic             stall,
  output logic [3:0]       ex_ctl,
  output logic [2:0]       mem_ctl,
  output logic [1:0]       wb_ctl,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned CTL_W = 9;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);

  // {regwrite, memtoreg, branch, memread, memwrite, regdst, aluop[1:0], alusrc}
  localparam logic [CTL_W-1:0] CTL_RTYPE = 9'b100001100;
  localparam logic [CTL_W-1:0] CTL_LW    = 9'b110100001;
  localparam logic [CTL_W-1:0] CTL_SW    = 9'b000010001;
  localparam logic [CTL_W-1:0] CTL_BEQ   = 9'b001000010;
  localparam logic [CTL_W-1:0] CTL_ADDI  = 9'b100000001;

  logic [CTL_W-1:0] ctl_dec;
  logic [CTL_W-1:0] id_ex_q,  id_ex_d;
  logic [REG_W-1:0] ex_rt_q,  ex_rt_d;
  logic [4:0]       ex_mem_q, ex_mem_d;
  logic [1:0]       mem_wb_q, mem_wb_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             hazard;

  // Opcode decode
  always_comb begin
    ctl_dec = '0;
    if (opcode == OP_RTYPE) begin
      ctl_dec = CTL_RTYPE;
    end else if (opcode == OP_LW) begin
      ctl_dec = CTL_LW;
    end else if (opcode == OP_SW) begin
      ctl_dec = CTL_SW;
    end else if (opcode == OP_BEQ) begin
      ctl_dec = CTL_BEQ;
    end else if ((opcode == OP_ADDI) && (EN_ADDI != 0)) begin
      ctl_dec = CTL_ADDI;
    end
  end

  // Load-use hazard; a flush squashes the consumer anyway, so it masks the stall
  always_comb begin
    hazard = id_valid & id_ex_q[5] & (ex_rt_q != '0) &
             ((ex_rt_q == id_rs) | (ex_rt_q == id_rt));
    stall  = hazard & ~flush;
  end

  // Next-state for the control latches and the saturating stall counter
  always_comb begin
    id_ex_d  = ctl_dec;
    ex_rt_d  = id_rt;
    ex_mem_d = id_ex_q[8:4];
    mem_wb_d = ex_mem_q[4:3];
    cnt_d    = cnt_q;
    if (flush) begin
      id_ex_d  = '0;
      ex_rt_d  = '0;
      ex_mem_d = '0;
    end else if (stall || !id_valid) begin
      id_ex_d  = '0;
      ex_rt_d  = '0;
    end
    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q  <= '0;
      ex_rt_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
      cnt_q    <= '0;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_rt_q  <= ex_rt_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ex_ctl    = id_ex_q[3:0];
  assign mem_ctl   = ex_mem_q[2:0];
  assign wb_ctl    = mem_wb_q;
  assign stall_cnt = cnt_q;

endmodule
